// File: rtl/err_pkg.sv
// err_pkg: shared encodings and default sizes for the error-injection blocks
package err_pkg;
  localparam int ERR_N = 8;
  localparam int ERR_CNT_W = 16;
  typedef enum logic [1:0] {ERR_PASS = 2'd0, ERR_OR = 2'd1, ERR_XOR = 2'd2, ERR_ANDN = 2'd3} err_mode_t;
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, DONE = 2'd2} err_state_t;
endpackage

// File: rtl/err_apply.sv
// err_apply: combinational corruption of one word by a mask
// Ports: mode (corruption type), mask (bits to hit), data (word in),
//        en (apply corruption this word), data_o (possibly corrupted word)
module err_apply
  import err_pkg::*;
#(
  parameter int N = ERR_N
) (
  input  err_mode_t      mode,
  input  logic [N-1:0]   mask,
  input  logic [N-1:0]   data,
  input  logic           en,
  output logic [N-1:0]   data_o
);
  always_comb
    data_o = !en               ? data :
             mode == ERR_OR    ? data | mask :
             mode == ERR_XOR   ? data ^ mask :
             mode == ERR_ANDN  ? data & ~mask :
                                 data;
endmodule

// File: rtl/err_inject_ctrl.sv
// err_inject_ctrl: scheduled error injector inline on a valid/ready stream
// Ports: clk/rst (async active-high); start/abort control pulses;
//        mode/walk/err_mask/delay/period/count run config sampled on start;
//        in_valid/in_ready/in_data upstream; out_valid/out_ready/out_data/out_err
//        downstream with injection flag; busy (armed), done (run end pulse),
//        inj_total (saturating injection count since reset)
module err_inject_ctrl
  import err_pkg::*;
#(
  parameter int N = ERR_N,
  parameter int CNT_W = ERR_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       mode,
  input  logic             walk,
  input  logic [N-1:0]     err_mask,
  input  logic [CNT_W-1:0] delay,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] count,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic             out_err,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] inj_total
);
  err_state_t state, state_nx;
  err_mode_t mode_r;
  logic walk_r;
  logic [N-1:0] mask_cur, applied;
  logic [CNT_W-1:0] gap, remaining, period_r;
  logic accept, armed_accept, inject_now, arm;
  assign in_ready = !out_valid || out_ready;
  assign accept = in_valid && in_ready;
  // abort takes priority over any scheduling activity in the same cycle
  assign armed_accept = state == ARMED && accept && !abort;
  assign inject_now = armed_accept && gap == '0;
  assign arm = state == IDLE && start && !abort && count != '0;
  assign busy = state == ARMED;
  assign done = state == DONE;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    state_nx = abort ? IDLE :
               state == IDLE  ? (start ? (count == '0 ? DONE : ARMED) : IDLE) :
               state == ARMED ? (inject_now && remaining == CNT_W'(1) ? DONE : ARMED) :
                                IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mode_r <= ERR_PASS;
      walk_r <= 1'b0;
      mask_cur <= '0;
      gap <= '0;
      remaining <= '0;
      period_r <= '0;
      inj_total <= '0;
    end else begin
      if (arm) begin
        mode_r <= err_mode_t'(mode);
        walk_r <= walk;
        mask_cur <= err_mask;
        gap <= delay;
        remaining <= count;
        period_r <= period;
      end else if (inject_now) begin
        remaining <= remaining - CNT_W'(1);
        gap <= period_r;
        if (walk_r) mask_cur <= {mask_cur[N-2:0], mask_cur[N-1]};
      end else if (armed_accept) begin
        gap <= gap - CNT_W'(1);
      end
      if (inject_now && !(&inj_total)) inj_total <= inj_total + CNT_W'(1);
    end
  err_apply #(.N(N)) u_apply (
    .mode(mode_r),
    .mask(mask_cur),
    .data(in_data),
    .en(inject_now),
    .data_o(applied)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_err <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data <= applied;
      out_err <= inject_now;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
endmodule
